// File: rtl/snake_pkg.sv
// Shared types and sizes for the snake grid rasteriser.
package snake_pkg;

    localparam int GRID_W = 16;
    localparam int NCELLS = GRID_W * GRID_W;

    typedef logic [7:0] pos_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BODY  = 2'd1,
        HEAD  = 2'd2,
        FOOD  = 2'd3
    } cell_t;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        PLOT,
        SWAP
    } build_state_t;

    // A zero length still plots the head.
    function automatic pos_t eff_len(input pos_t len);
        return (len == '0) ? pos_t'(1) : len;
    endfunction

endpackage

// File: rtl/snake_grid_buffer.sv
// Double-buffered 16x16 cell-code framebuffer: clear-with-food, HEAD-protected write,
// registered read from the front bank.
module snake_grid_buffer
    import snake_pkg::*;
(
    input  logic  clk,
    input  logic  reset_n,
    input  logic  clr,
    input  pos_t  clr_food,
    input  logic  we,
    input  pos_t  waddr,
    input  cell_t wcode,
    input  logic  swap,
    input  pos_t  rd_addr,
    output cell_t rd_cell
);

    cell_t bank [2][NCELLS];
    logic  front_sel;
    logic  back_sel;

    assign back_sel = ~front_sel;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            front_sel <= 1'b0;
            rd_cell   <= EMPTY;
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < NCELLS; i++) begin
                    bank[b][i] <= EMPTY;
                end
            end
        end else begin
            // Reads use the pre-swap front select, so a read on the swap edge sees old data.
            rd_cell <= bank[front_sel][rd_addr];
            if (swap) begin
                front_sel <= ~front_sel;
            end
            if (clr) begin
                for (int i = 0; i < NCELLS; i++) begin
                    bank[back_sel][i] <= (pos_t'(i) == clr_food) ? FOOD : EMPTY;
                end
            end else if (we && !(wcode == BODY && bank[back_sel][waddr] == HEAD)) begin
                bank[back_sel][waddr] <= wcode;
            end
        end
    end

endmodule

// File: rtl/snake_grid_builder.sv
// Rasterises snake positions and food into a double-buffered 16x16 grid once per tick.
// Define SELF_HIT_DETECT_EN to include head-on-body collision detection.
module snake_grid_builder
    import snake_pkg::*;
(
    input  logic  clk,
    input  logic  reset_n,
    input  pos_t  positions [NCELLS],
    input  pos_t  length,
    input  pos_t  foodPos,
    input  logic  start,
    output logic  busy,
    output logic  frame_done,
    output logic  overrun,
    output logic  self_hit,
    input  pos_t  rd_addr,
    output cell_t rd_cell
);

    build_state_t state;
    pos_t         len_q;
    pos_t         food_q;
    pos_t         idx;
`ifdef SELF_HIT_DETECT_EN
    logic         hit_acc;
`endif

    logic  buf_clr;
    logic  buf_we;
    logic  buf_swap;
    pos_t  buf_waddr;
    cell_t buf_wcode;

    assign buf_clr   = (state == CLEAR);
    assign buf_we    = (state == PLOT);
    assign buf_swap  = (state == SWAP);
    assign buf_waddr = positions[idx];
    assign buf_wcode = (idx == '0) ? HEAD : BODY;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
            self_hit   <= 1'b0;
            len_q      <= '0;
            food_q     <= '0;
            idx        <= '0;
`ifdef SELF_HIT_DETECT_EN
            hit_acc    <= 1'b0;
`endif
        end else begin
            frame_done <= 1'b0;
            // Requests during a build are dropped, not queued.
            if (start && state != IDLE) begin
                overrun <= 1'b1;
            end
            unique case (state)
                IDLE: begin
                    if (start) begin
                        len_q  <= eff_len(length);
                        food_q <= foodPos;
                        busy   <= 1'b1;
                        state  <= CLEAR;
                    end
                end
                CLEAR: begin
                    idx   <= '0;
                    state <= PLOT;
                end
                PLOT: begin
`ifdef SELF_HIT_DETECT_EN
                    if (idx != '0 && positions[idx] == positions[0]) begin
                        hit_acc <= 1'b1;
                    end
`endif
                    if (idx == len_q - 8'd1) begin
                        state <= SWAP;
                    end else begin
                        idx <= idx + 8'd1;
                    end
                end
                SWAP: begin
`ifdef SELF_HIT_DETECT_EN
                    self_hit <= hit_acc;
                    hit_acc  <= 1'b0;
`endif
                    busy       <= 1'b0;
                    frame_done <= 1'b1;
                    state      <= IDLE;
                end
            endcase
        end
    end

    snake_grid_buffer u_buffer (
        .clk      (clk),
        .reset_n  (reset_n),
        .clr      (buf_clr),
        .clr_food (food_q),
        .we       (buf_we),
        .waddr    (buf_waddr),
        .wcode    (buf_wcode),
        .swap     (buf_swap),
        .rd_addr  (rd_addr),
        .rd_cell  (rd_cell)
    );

endmodule

// File: tb/tb_snake_grid_builder.sv
// Bench for snake_grid_builder: frame-level reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_snake_grid_builder;
    import snake_pkg::*;

`ifdef SELF_HIT_DETECT_EN
    localparam int HitEn = 1;
`else
    localparam int HitEn = 0;
`endif

    logic  clk = 1'b0;
    logic  reset_n = 1'b0;
    pos_t  positions [NCELLS];
    pos_t  length = '0;
    pos_t  foodPos = '0;
    logic  start = 1'b0;
    pos_t  rd_addr = '0;
    logic  busy;
    logic  frame_done;
    logic  overrun;
    logic  self_hit;
    cell_t rd_cell;

    always #5 clk = ~clk;

    snake_grid_builder dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .positions  (positions),
        .length     (length),
        .foodPos    (foodPos),
        .start      (start),
        .busy       (busy),
        .frame_done (frame_done),
        .overrun    (overrun),
        .self_hit   (self_hit),
        .rd_addr    (rd_addr),
        .rd_cell    (rd_cell)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endtask

    // Frame-level model: a build takes L+2 edges after the accepting edge, then the
    // freshly composed grid becomes the front.
    int m_front [NCELLS];
    int m_back  [NCELLS];
    int m_rem = 0;
    int m_done = 0;
    int m_over = 0;
    int m_hit = 0;
    int m_hit_pend = 0;
    int m_rd = 0;
    int m_len = 0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            foreach (m_front[i]) m_front[i] = 0;
            m_rem = 0; m_done = 0; m_over = 0; m_hit = 0; m_rd = 0;
        end else begin
            m_rd = m_front[rd_addr];
            m_done = 0;
            if (m_rem > 0) begin
                if (start) m_over = 1;
                m_rem--;
                if (m_rem == 0) begin
                    m_front = m_back;
                    m_hit = (HitEn != 0) ? m_hit_pend : 0;
                    m_done = 1;
                end
            end else if (start) begin
                m_len = (length == 0) ? 1 : int'(length);
                foreach (m_back[i]) m_back[i] = 0;
                m_back[foodPos] = 3;
                m_hit_pend = 0;
                for (int i = 1; i < m_len; i++) begin
                    m_back[positions[i]] = 1;
                    if (positions[i] == positions[0]) m_hit_pend = 1;
                end
                m_back[positions[0]] = 2;
                m_rem = m_len + 2;
            end
        end
    end

    always @(negedge clk) begin
        check("busy", int'(busy), int'(m_rem > 0));
        check("frame_done", int'(frame_done), m_done);
        check("overrun", int'(overrun), m_over);
        check("self_hit", int'(self_hit), m_hit);
        check("rd_cell", int'(rd_cell), m_rd);
    end

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_done(output int lat, output int bcnt);
        lat = 0;
        bcnt = 0;
        while (lat < 400) begin
            @(negedge clk);
            if (frame_done) break;
            if (busy) bcnt++;
            lat++;
        end
        if (lat >= 400) check("frame_done_timeout", 0, 1);
    endtask

    task automatic build(input int len, input int food, output int lat, output int bcnt);
        length = pos_t'(len);
        foodPos = pos_t'(food);
        pulse_start();
        wait_done(lat, bcnt);
    endtask

    task automatic read_cell(input int a, output int v);
        @(posedge clk); #1 rd_addr = pos_t'(a);
        @(posedge clk);
        @(negedge clk);
        v = int'(rd_cell);
    endtask

    task automatic read_check(input int a, input int exp, input string nm);
        int v;
        read_cell(a, v);
        check(nm, v, exp);
    endtask

    task automatic sweep();
        for (int a = 0; a < NCELLS; a++) begin
            @(posedge clk); #1 rd_addr = pos_t'(a);
        end
    endtask

    task automatic count_done(input int cycles, output int n);
        n = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (frame_done) n++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, bc, n, v, nb, nh;
        foreach (positions[i]) positions[i] = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_frame_done", int'(frame_done), 0);
        check("rst_overrun", int'(overrun), 0);
        check("rst_self_hit", int'(self_hit), 0);
        check("rst_rd_cell", int'(rd_cell), 0);
        #1 reset_n = 1'b1;

        // Single head with food
        positions[0] = 8'd58;
        build(1, 144, lat, bc);
        check("t1_latency", lat, 3);
        check("t1_self_hit", int'(self_hit), 0);
        read_check(58, 2, "t1_head");
        read_check(144, 3, "t1_food");
        read_check(0, 0, "t1_empty");

        // Three-cell body
        positions[0] = 8'd34; positions[1] = 8'd33; positions[2] = 8'd32;
        build(3, 200, lat, bc);
        check("t2_latency", lat, 5);
        read_check(34, 2, "t2_head");
        read_check(33, 1, "t2_body33");
        read_check(32, 1, "t2_body32");
        read_check(200, 3, "t2_food");
        read_check(35, 0, "t2_empty");
        sweep();

        // Self collision, tail re-enters the head cell
        positions[0] = 8'd17; positions[1] = 8'd18; positions[2] = 8'd33; positions[3] = 8'd17;
        build(4, 99, lat, bc);
        check("t3_self_hit", int'(self_hit), HitEn);
        read_check(17, 2, "t3_head_kept");
        read_check(18, 1, "t3_body");
        positions[0] = 8'd18; positions[1] = 8'd17;
        build(2, 99, lat, bc);
        check("t3_self_hit_clear", int'(self_hit), 0);
        read_check(18, 2, "t3b_head");
        read_check(17, 1, "t3b_body");
        read_check(33, 0, "t3b_empty");

        // Overrun and double buffering; rd_addr stays on the old head cell
        for (int i = 0; i < 10; i++) positions[i] = pos_t'(100 + i);
        @(posedge clk); #1 rd_addr = 8'd18;
        length = 8'd10;
        foodPos = 8'd250;
        pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        check("t4_overrun", int'(overrun), 1);
        check("t4_old_front", int'(rd_cell), 2);
        wait_done(lat, bc);
        check("t4_rd_on_swap", int'(rd_cell), 2);
        @(negedge clk);
        check("t4_rd_after_swap", int'(rd_cell), 0);
        count_done(30, n);
        check("t4_single_done", n, 0);
        read_check(100, 2, "t4_head");
        read_check(250, 3, "t4_food");

        // Reset in the middle of PLOT
        for (int i = 0; i < 20; i++) positions[i] = pos_t'(120 + i);
        length = 8'd20;
        foodPos = 8'd7;
        pulse_start();
        repeat (5) @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        check("t5_busy", int'(busy), 0);
        check("t5_frame_done", int'(frame_done), 0);
        check("t5_overrun", int'(overrun), 0);
        check("t5_self_hit", int'(self_hit), 0);
        check("t5_rd_cell", int'(rd_cell), 0);
        @(negedge clk); #1 reset_n = 1'b1;
        count_done(40, n);
        check("t5_no_done", n, 0);
        read_check(120, 0, "t5_pos_empty");
        read_check(7, 0, "t5_food_empty");
        read_check(100, 0, "t5_old_empty");

        // Length 0 behaves as 1
        positions[0] = 8'd77;
        build(0, 5, lat, bc);
        check("t6_latency", lat, 3);
        read_check(77, 2, "t6_head");
        read_check(5, 3, "t6_food");
        read_check(121, 0, "t6_entry1_unused");

        // Length 255, all distinct
        for (int i = 0; i < 255; i++) positions[i] = pos_t'(i);
        build(255, 255, lat, bc);
        check("t7_busy_cycles", bc, 257);
        check("t7_latency", lat, 257);
        nb = 0;
        nh = 0;
        for (int a = 0; a < NCELLS; a++) begin
            read_cell(a, v);
            if (v == 1) nb++;
            if (v == 2) nh++;
        end
        check("t7_body_count", nb, 254);
        check("t7_head_count", nh, 1);
        read_check(255, 3, "t7_food");
        read_check(0, 2, "t7_head");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
